// File: rtl/hwjsoc_vjtag_pkg.sv
// hwjsoc_vjtag_pkg: shared state encoding, IR codes and DR width for the virtual-JTAG scan master
package hwjsoc_vjtag_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UIR  = 3'd1,
    CDR  = 3'd2,
    SDR  = 3'd3,
    UDR  = 3'd4,
    RTI  = 3'd5
  } state_t;
  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;
  localparam int DEBUG_DR_WIDTH = 38;
endpackage

// File: rtl/hwjsoc_vjtag_tck_gen.sv
// hwjsoc_vjtag_tck_gen: divides clk into tck (low phase first) and flags the cycles that end each phase
module hwjsoc_vjtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(2 * TCK_DIV) + 1;
  logic [CW-1:0] cnt;
  assign rise = run && cnt == CW'(TCK_DIV - 1);
  assign fall = run && cnt == CW'(2 * TCK_DIV - 1);
  assign tck  = cnt >= CW'(TCK_DIV);
  // phase counter parks at zero while stopped so tck stays low in idle
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (!run || fall) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/hwjsoc_vjtag_scan_master.sv
// hwjsoc_vjtag_scan_master: performs one virtual IR load plus one DR scan per command and returns captured tdo
module hwjsoc_vjtag_scan_master
  import hwjsoc_vjtag_pkg::*;
#(
  parameter int DR_WIDTH = DEBUG_DR_WIDTH,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic [IR_WIDTH-1:0] ir_readback,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);
  localparam int IW = $clog2(DR_WIDTH + 1);
  state_t state, nxt;
  logic [DR_WIDTH-1:0] sr;
  logic [IW-1:0] idx;
  logic tdo_q, rise, fall, accept, last;
  assign cmd_ready = state == IDLE;
  assign accept    = cmd_valid && cmd_ready;
  assign last      = idx == IW'(DR_WIDTH - 1);
  assign vji_uir   = state == UIR;
  assign vji_cdr   = state == CDR;
  assign vji_sdr   = state == SDR;
  assign vji_udr   = state == UDR;
  assign vji_rti   = state == RTI;
  assign vji_tdi   = vji_sdr & sr[0];
  hwjsoc_vjtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk  (clk),
    .reset(reset),
    .run  (!cmd_ready),
    .tck  (vji_tck),
    .rise (rise),
    .fall (fall)
  );
  // state to enter at the end of the current tck period
  always_comb
    nxt = state == UIR ? CDR :
          state == CDR ? SDR :
          state == SDR ? (last ? UDR : SDR) :
          state == UDR ? RTI : IDLE;
  // sequencer: one period per state, DR_WIDTH periods in SDR tracked by idx
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else if (accept) begin
      state <= UIR;
      idx   <= '0;
    end else if (fall) begin
      state <= nxt;
      if (vji_sdr) idx <= last ? '0 : idx + 1'b1;
    end
  // datapath: sr shifts data out of bit 0 while captured tdo enters at the MSB
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr          <= '0;
      tdo_q       <= 1'b0;
      rsp_dr      <= '0;
      rsp_valid   <= 1'b0;
      ir_readback <= '0;
      vji_ir_in   <= '0;
    end else begin
      rsp_valid <= fall && vji_rti;
      if (accept) begin
        vji_ir_in <= cmd_ir;
        sr        <= cmd_dr;
      end
      if (rise && vji_uir) ir_readback <= vji_ir_out;
      if (rise && vji_sdr) tdo_q <= vji_tdo;
      if (fall && vji_sdr) sr <= {tdo_q, sr[DR_WIDTH-1:1]};
      if (fall && vji_rti) rsp_dr <= sr;
    end
endmodule

// File: tb/tb_hwjsoc_vjtag_scan_master.sv
// tb_hwjsoc_vjtag_scan_master: directed vector and sequence checks of the scan master at TCK_DIV 2, 1 and 3
module tb_hwjsoc_vjtag_scan_master;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int tests = 0, fails = 0, idle_bad = 0;

  logic v, rdy, rv, tck, tdi, tdo, uir, cdr, sdr, udr, rti;
  logic [1:0] ir, ir_in, ir_out, rb;
  logic [37:0] dr, rdr, m, pat;
  logic v1, rdy1, rv1, tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;
  logic [1:0] ir1, ir_in1, rb1;
  logic [37:0] dr1, rdr1;
  logic v3, rdy3, rv3, tck3, tdi3, uir3, cdr3, sdr3, udr3, rti3;
  logic [1:0] ir3, ir_in3, rb3;
  logic [37:0] dr3, rdr3;

  hwjsoc_vjtag_scan_master d (
    .clk(clk), .reset(reset), .cmd_valid(v), .cmd_ready(rdy), .cmd_ir(ir), .cmd_dr(dr),
    .rsp_valid(rv), .rsp_dr(rdr), .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo),
    .vji_ir_in(ir_in), .vji_ir_out(ir_out), .ir_readback(rb),
    .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti));
  hwjsoc_vjtag_scan_master #(.TCK_DIV(1)) d1 (
    .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_ir(ir1), .cmd_dr(dr1),
    .rsp_valid(rv1), .rsp_dr(rdr1), .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(1'b0),
    .vji_ir_in(ir_in1), .vji_ir_out(2'b00), .ir_readback(rb1),
    .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1));
  hwjsoc_vjtag_scan_master #(.TCK_DIV(3)) d3 (
    .clk(clk), .reset(reset), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_ir(ir3), .cmd_dr(dr3),
    .rsp_valid(rv3), .rsp_dr(rdr3), .vji_tck(tck3), .vji_tdi(tdi3), .vji_tdo(1'b0),
    .vji_ir_in(ir_in3), .vji_ir_out(2'b00), .ir_readback(rb3),
    .vji_uir(uir3), .vji_cdr(cdr3), .vji_sdr(sdr3), .vji_udr(udr3), .vji_rti(rti3));

  // loopback target: loads pat in CDR, shifts LSB-out / tdi-in on each SDR tck rise
  assign tdo = m[0];
  assign ir_out = ir_in;
  always @(posedge tck)
    if (cdr) m <= pat;
    else if (sdr) m <= {tdi, m[37:1]};

  // tck must stay low whenever a master is idle
  always @(negedge clk)
    if (!reset && ((rdy && tck) || (rdy1 && tck1) || (rdy3 && tck3))) idle_bad++;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic start(input logic [1:0] i, input logic [37:0] x);
    for (int n = 0; n < 1000 && !rdy; n++) @(negedge clk);
    ir = i;
    dr = x;
    v = 1'b1;
    @(posedge clk);
    #1 v = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc, output int busy);
    cyc = -1;
    busy = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (rv) begin
        cyc = c;
        break;
      end
      if (rdy) busy++;
    end
  endtask

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] dr;
    logic [37:0] pat;
    logic [37:0] rsp;
    logic [37:0] mdl;
  } vec_t;
  vec_t tv[4];

  initial begin
    int cyc, busy, c2, b2, bad, ones;
    int r[5];
    logic prevt;
    logic [5:0] e;
    tv[0] = '{2'b00, 38'h15_1234_5678, 38'h2A_5A5A_5A5A, 38'h2A_5A5A_5A5A, 38'h15_1234_5678};
    tv[1] = '{2'b10, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 38'h00_0000_0000, 38'h3F_FFFF_FFFF};
    tv[2] = '{2'b01, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF, 38'h00_0000_0000};
    tv[3] = '{2'b11, 38'h00_0000_0001, 38'h20_0000_0000, 38'h20_0000_0000, 38'h00_0000_0001};
    v = 0; ir = 0; dr = 0; pat = 0;
    v1 = 0; ir1 = 0; dr1 = 0;
    v3 = 0; ir3 = 0; dr3 = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(rdy), 64'd1);
    chk("reset_rsp_valid", 64'(rv), 64'd0);
    chk("reset_rsp_dr", 64'(rdr), 64'd0);
    chk("reset_pins", 64'({tck, tdi, ir_in, rb, uir, cdr, sdr, udr, rti}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      pat = tv[k].pat;
      start(tv[k].ir, tv[k].dr);
      wait_rsp(cyc, busy);
      chk("latency", 64'(cyc), 64'd169);
      chk("busy_ready_low", 64'(busy), 64'd0);
      chk("rsp_dr", 64'(rdr), 64'(tv[k].rsp));
      chk("model_dr", 64'(m), 64'(tv[k].mdl));
      chk("ir_readback", 64'(rb), 64'(tv[k].ir));
      repeat (5) @(negedge clk);
      chk("ir_in_held", 64'(ir_in), 64'(tv[k].ir));
    end

    pat = 38'h0F_0F0F_0F0F;
    start(2'b01, 38'h33_3333_3333);
    repeat (78) @(negedge clk);
    chk("mid_sdr", 64'(sdr), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_ready", 64'(rdy), 64'd1);
    chk("abort_rsp_valid", 64'(rv), 64'd0);
    chk("abort_rsp_dr", 64'(rdr), 64'd0);
    chk("abort_pins", 64'({tck, tdi, ir_in, rb, uir, cdr, sdr, udr, rti}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rv) bad++;
    end
    chk("no_rsp_after_abort", 64'(bad), 64'd0);
    start(2'b01, 38'h33_3333_3333);
    wait_rsp(cyc, busy);
    chk("post_abort_latency", 64'(cyc), 64'd169);
    chk("post_abort_rsp", 64'(rdr), 64'h0F_0F0F_0F0F);

    pat = 38'h12_3456_789A;
    ir = 2'b01;
    dr = 38'h2B_CDEF_0123;
    v = 1'b1;
    @(posedge clk);
    #1;
    ir = 2'b11;
    dr = 38'h11_2233_4455;
    wait_rsp(cyc, busy);
    chk("b2b_first_latency", 64'(cyc), 64'd169);
    chk("b2b_first_busy", 64'(busy), 64'd0);
    chk("b2b_held_ir", 64'(ir_in), 64'd1);
    chk("b2b_first_rsp", 64'(rdr), 64'h12_3456_789A);
    chk("b2b_first_model", 64'(m), 64'h2B_CDEF_0123);
    chk("b2b_ready_on_rsp", 64'(rdy), 64'd1);
    @(posedge clk);
    #1 v = 1'b0;
    chk("b2b_accepted", 64'(rdy), 64'd0);
    chk("b2b_second_ir", 64'(ir_in), 64'd3);
    wait_rsp(c2, b2);
    chk("b2b_spacing", 64'(c2), 64'd169);
    chk("b2b_second_busy", 64'(b2), 64'd0);
    chk("b2b_second_rsp", 64'(rdr), 64'h12_3456_789A);
    chk("b2b_second_model", 64'(m), 64'h11_2233_4455);

    dr1 = 38'h15_5555_5555;
    v1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0;
    bad = 0;
    prevt = 1'b0;
    r = '{0, 0, 0, 0, 0};
    for (int c = 1; c <= 85; c++) begin
      @(negedge clk);
      e = {c >= 1 && c <= 2, c >= 3 && c <= 4, c >= 5 && c <= 80,
           c >= 81 && c <= 82, c >= 83 && c <= 84, c == 85};
      if ({uir1, cdr1, sdr1, udr1, rti1, rv1} !== e) bad++;
      if (tck1 && !prevt) begin
        if (uir1) r[0]++;
        if (cdr1) r[1]++;
        if (sdr1) r[2]++;
        if (udr1) r[3]++;
        if (rti1) r[4]++;
      end
      prevt = tck1;
    end
    chk("div1_strobe_seq", 64'(bad), 64'd0);
    chk("div1_uir_rises", 64'(r[0]), 64'd1);
    chk("div1_cdr_rises", 64'(r[1]), 64'd1);
    chk("div1_sdr_rises", 64'(r[2]), 64'd38);
    chk("div1_udr_rises", 64'(r[3]), 64'd1);
    chk("div1_rti_rises", 64'(r[4]), 64'd1);

    dr3 = 38'h3F_FFFF_FFFF;
    v3 = 1'b1;
    @(posedge clk);
    #1 v3 = 1'b0;
    cyc = -1;
    ones = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (tdi3) ones++;
      if (rv3) begin
        cyc = c;
        break;
      end
    end
    chk("div3_latency", 64'(cyc), 64'd253);
    chk("div3_tdi_high", 64'(ones), 64'd228);
    chk("div3_rsp", 64'(rdr3), 64'd0);
    repeat (10) @(negedge clk);
    chk("idle_tck_quiet", 64'(idle_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
